// File: rtl/alu_sequencer.sv
// alu_sequencer: runs one complete Argon ALU operation per request.
// The request (A, B, opcode, incoming flags) is taken over a valid/ready
// handshake and drives the shared ALU bus through the sequence
// LATCHA, LATCHB, LATCHF, LATCHOP, COMPUTE, OUTPUTY, OUTPUTF. It captures the
// result word and the flags, then returns them over a second valid/ready
// handshake.
//
// Ports:
//   i_Clk, i_Reset_n            clock, async active-low reset
//   i_ReqValid/o_ReqReady       request handshake; i_ReqA/B/Op/Flags payload
//   o_Command/o_BusData/o_BusValid  ALU bus drive
//   i_AluData/i_AluValid        ALU read-back (sampled in RD_Y/RD_F only)
//   o_ResValid/i_ResReady       result handshake; o_ResY/o_ResFlags/o_ResErr
//   o_OpCount                   completed result handshakes (wraps)
//
// Optional feature macro: ALU_SEQ_FLAG_SKIP_EN. When it is defined, LATCHF is
// issued only for ADC/SBB, which shortens every other operation by one cycle.
//
// State table:
//   IDLE    | waiting for a request, o_ReqReady=1
//   LD_A    | COM_LATCHA, bus = A
//   LD_B    | COM_LATCHB, bus = B
//   LD_F    | COM_LATCHF, bus = {8'h00, flags}
//   LD_OP   | COM_LATCHOP, bus = {12'h000, op}
//   COMPUTE | COM_COMPUTE
//   RD_Y    | COM_OUTPUTY, capture result word
//   RD_F    | COM_OUTPUTF, capture flags
//   DONE    | o_ResValid=1, hold until i_ResReady

package constants_pkg;
  localparam int WORDSIZE = 16;
  typedef logic [3:0] com_t;
  localparam com_t COM_NOP     = 4'd0;
  localparam com_t COM_LATCHA  = 4'd1;
  localparam com_t COM_LATCHB  = 4'd2;
  localparam com_t COM_LATCHF  = 4'd3;
  localparam com_t COM_LATCHOP = 4'd4;
  localparam com_t COM_COMPUTE = 4'd5;
  localparam com_t COM_OUTPUTY = 4'd6;
  localparam com_t COM_OUTPUTF = 4'd7;
endpackage

package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ADC = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_SBB = 4'd3;
  localparam int F_CARRY = 0;
  localparam int F_ZERO  = 1;
endpackage

module alu_sequencer
  import constants_pkg::*;
  import alu_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Reset_n,
  input  logic                i_ReqValid,
  output logic                o_ReqReady,
  input  logic [WORDSIZE-1:0] i_ReqA,
  input  logic [WORDSIZE-1:0] i_ReqB,
  input  logic [3:0]          i_ReqOp,
  input  logic [7:0]          i_ReqFlags,
  output com_t                o_Command,
  output logic [WORDSIZE-1:0] o_BusData,
  output logic                o_BusValid,
  input  logic [WORDSIZE-1:0] i_AluData,
  input  logic                i_AluValid,
  output logic                o_ResValid,
  input  logic                i_ResReady,
  output logic [WORDSIZE-1:0] o_ResY,
  output logic [7:0]          o_ResFlags,
  output logic                o_ResErr,
  output logic [15:0]         o_OpCount
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_A, S_LD_B, S_LD_F, S_LD_OP, S_COMPUTE, S_RD_Y, S_RD_F, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WORDSIZE-1:0] a_q, a_d, b_q, b_d, res_y_q, res_y_d;
  logic [3:0]          op_q, op_d;
  logic [7:0]          flags_q, flags_d, res_flags_q, res_flags_d;
  logic                err_q, err_d;
  logic [15:0]         count_q, count_d;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      flags_q     <= '0;
      res_y_q     <= '0;
      res_flags_q <= '0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      flags_q     <= flags_d;
      res_y_q     <= res_y_d;
      res_flags_q <= res_flags_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    flags_d     = flags_q;
    res_y_d     = res_y_q;
    res_flags_d = res_flags_q;
    err_d       = err_q;
    count_d     = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_ReqValid) begin
          state_d = S_LD_A;
          a_d     = i_ReqA;
          b_d     = i_ReqB;
          op_d    = i_ReqOp;
          flags_d = i_ReqFlags;
          err_d   = 1'b0;
        end
      end
      S_LD_A: state_d = S_LD_B;
      S_LD_B: begin
`ifdef ALU_SEQ_FLAG_SKIP_EN
        // Only the carry/borrow-in ops need the flags loaded first.
        if (op_q == ALU_ADC || op_q == ALU_SBB) state_d = S_LD_F;
        else                                     state_d = S_LD_OP;
`else
        state_d = S_LD_F;
`endif
      end
      S_LD_F:    state_d = S_LD_OP;
      S_LD_OP:   state_d = S_COMPUTE;
      S_COMPUTE: state_d = S_RD_Y;
      S_RD_Y: begin
        state_d = S_RD_F;
        res_y_d = i_AluData;
        if (!i_AluValid) err_d = 1'b1;
      end
      S_RD_F: begin
        state_d     = S_DONE;
        res_flags_d = i_AluData[7:0];
        if (!i_AluValid) err_d = 1'b1;
      end
      S_DONE: begin
        if (i_ResReady) begin
          state_d = S_IDLE;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus drive is decoded from state alone, so there is no path from the
  // handshake inputs to the ALU bus.
  always_comb begin
    o_Command  = COM_NOP;
    o_BusData  = '0;
    o_BusValid = 1'b0;
    unique case (state_q)
      S_LD_A:    begin o_Command = COM_LATCHA;  o_BusData = a_q;              o_BusValid = 1'b1; end
      S_LD_B:    begin o_Command = COM_LATCHB;  o_BusData = b_q;              o_BusValid = 1'b1; end
      S_LD_F:    begin o_Command = COM_LATCHF;  o_BusData = {8'h00, flags_q}; o_BusValid = 1'b1; end
      S_LD_OP:   begin o_Command = COM_LATCHOP; o_BusData = {12'h000, op_q};  o_BusValid = 1'b1; end
      S_COMPUTE: o_Command = COM_COMPUTE;
      S_RD_Y:    o_Command = COM_OUTPUTY;
      S_RD_F:    o_Command = COM_OUTPUTF;
      default:   o_Command = COM_NOP;
    endcase
  end

  assign o_ReqReady = (state_q == S_IDLE);
  assign o_ResValid = (state_q == S_DONE);
  assign o_ResY     = res_y_q;
  assign o_ResFlags = res_flags_q;
  assign o_ResErr   = err_q;
  assign o_OpCount  = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import constants_pkg::*;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0, req_b = '0;
  logic [3:0]  req_op = '0;
  logic [7:0]  req_flags = '0;
  com_t        command;
  logic [15:0] bus_data;
  logic        bus_valid;
  logic [15:0] alu_data;
  logic        alu_valid;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_y;
  logic [7:0]  res_flags;
  logic        res_err;
  logic [15:0] op_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Stand-in for the Argon ALU (ADD/ADC only).
  logic [15:0] m_a = '0, m_b = '0, m_y = '0;
  logic [7:0]  m_f = '0;
  logic [3:0]  m_op = '0;
  logic        kill_f = 1'b0;
  logic [16:0] m_sum;

  always @(posedge clk) begin
    if (bus_valid && command == COM_LATCHA)  m_a  <= bus_data;
    if (bus_valid && command == COM_LATCHB)  m_b  <= bus_data;
    if (bus_valid && command == COM_LATCHF)  m_f  <= bus_data[7:0];
    if (bus_valid && command == COM_LATCHOP) m_op <= bus_data[3:0];
    if (command == COM_COMPUTE) begin
      m_sum = {1'b0, m_a} + {1'b0, m_b} + ((m_op == ALU_ADC) ? {16'd0, m_f[F_CARRY]} : 17'd0);
      m_y <= m_sum[15:0];
      m_f <= {6'b0, (m_sum[15:0] == 16'd0), m_sum[16]};
    end
  end

  always_comb begin
    alu_data  = '0;
    alu_valid = 1'b0;
    if (command == COM_OUTPUTY) begin alu_data = m_y; alu_valid = 1'b1; end
    if (command == COM_OUTPUTF) begin alu_data = {8'h00, m_f}; alu_valid = !kill_f; end
  end

  alu_sequencer dut (
    .i_Clk(clk), .i_Reset_n(rst_n),
    .i_ReqValid(req_valid), .o_ReqReady(req_ready),
    .i_ReqA(req_a), .i_ReqB(req_b), .i_ReqOp(req_op), .i_ReqFlags(req_flags),
    .o_Command(command), .o_BusData(bus_data), .o_BusValid(bus_valid),
    .i_AluData(alu_data), .i_AluValid(alu_valid),
    .o_ResValid(res_valid), .i_ResReady(res_ready),
    .o_ResY(res_y), .o_ResFlags(res_flags), .o_ResErr(res_err),
    .o_OpCount(op_count)
  );

  always #5 clk = ~clk;

`ifdef ALU_SEQ_FLAG_SKIP_EN
  localparam logic [31:0] ADD_SEQ = 32'h0012_4567;
  localparam int          ADD_LAT = 6;
`else
  localparam logic [31:0] ADD_SEQ = 32'h0123_4567;
  localparam int          ADD_LAT = 7;
`endif

  // Issues one request and returns at the first falling edge with o_ResValid
  // high. lat = rising edges after acceptance until o_ResValid (-1 on
  // timeout). seq/bus record the command/bus data of each intervening cycle,
  // with the oldest cycle in the upper bits.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                       input logic [7:0] fl, output int lat, output logic [31:0] seq,
                       output logic [127:0] bus);
    lat = -1; seq = '0; bus = '0;
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_flags = fl; req_valid = 1'b1;
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (res_valid) begin lat = k; break; end
      seq = {seq[27:0], command};
      bus = {bus[111:0], bus_data};
    end
  endtask

  task automatic retire();
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++; if (req_ready !== 1'b1)   begin tests_failed++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    tests_run++; if (command !== COM_NOP)  begin tests_failed++; $display("FAIL reset_command got %0h want %0h", command, COM_NOP); end
    tests_run++; if (res_valid !== 1'b0)   begin tests_failed++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
    tests_run++; if (bus_valid !== 1'b0)   begin tests_failed++; $display("FAIL reset_bus_valid got %0b want 0", bus_valid); end
    tests_run++; if (op_count !== 16'd0)   begin tests_failed++; $display("FAIL reset_op_count got %0h want 0", op_count); end
    tests_run++; if (res_y !== 16'd0 || res_flags !== 8'd0 || res_err !== 1'b0)
      begin tests_failed++; $display("FAIL reset_results got y=%0h f=%0h e=%0b want 0/0/0", res_y, res_flags, res_err); end
  endtask

  task automatic test_add();
    int lat; logic [31:0] seq; logic [127:0] bus;
    issue(16'h0001, 16'h0002, ALU_ADD, 8'h00, lat, seq, bus);
    tests_run++; if (seq !== ADD_SEQ) begin tests_failed++; $display("FAIL add_cmd_seq got %h want %h", seq, ADD_SEQ); end
    tests_run++; if (lat !== ADD_LAT) begin tests_failed++; $display("FAIL add_latency got %0d want %0d", lat, ADD_LAT); end
    tests_run++; if (res_y !== 16'h0003) begin tests_failed++; $display("FAIL add_y got %h want 0003", res_y); end
    tests_run++; if (res_flags[F_CARRY] !== 1'b0 || res_flags[F_ZERO] !== 1'b0)
      begin tests_failed++; $display("FAIL add_flags got %h want carry=0 zero=0", res_flags); end
    tests_run++; if (res_err !== 1'b0) begin tests_failed++; $display("FAIL add_err got %0b want 0", res_err); end
    retire();
    tests_run++; if (op_count !== 16'd1) begin tests_failed++; $display("FAIL add_op_count got %0d want 1", op_count); end
    tests_run++; if (req_ready !== 1'b1 || res_valid !== 1'b0)
      begin tests_failed++; $display("FAIL add_back_idle got rdy=%0b vld=%0b want 1/0", req_ready, res_valid); end
  endtask

  task automatic test_add_overflow();
    int lat; logic [31:0] seq; logic [127:0] bus;
    issue(16'hFFFF, 16'h0001, ALU_ADD, 8'h00, lat, seq, bus);
    tests_run++; if (res_y !== 16'h0000) begin tests_failed++; $display("FAIL ovf_y got %h want 0000", res_y); end
    tests_run++; if (res_flags[F_CARRY] !== 1'b1) begin tests_failed++; $display("FAIL ovf_carry got %h want carry=1", res_flags); end
    tests_run++; if (res_flags[F_ZERO] !== 1'b1)  begin tests_failed++; $display("FAIL ovf_zero got %h want zero=1", res_flags); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] seq; logic [127:0] bus;
    issue(16'h0005, 16'h0007, ALU_ADD, 8'h00, lat, seq, bus);
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (res_y !== 16'h000C || res_flags !== 8'h00 || req_ready !== 1'b0 ||
          command !== COM_NOP || res_valid !== 1'b1)
        begin tests_failed++;
          $display("FAIL bp_hold c=%0d got y=%h f=%h rdy=%0b cmd=%0h vld=%0b want 000c/00/0/0/1",
                   c, res_y, res_flags, req_ready, command, res_valid); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    retire();
    tests_run++; if (req_ready !== 1'b1 || res_valid !== 1'b0 || command !== COM_NOP)
      begin tests_failed++; $display("FAIL bp_release got rdy=%0b vld=%0b cmd=%0h want 1/0/0", req_ready, res_valid, command); end
    tests_run++; if (op_count !== 16'd3) begin tests_failed++; $display("FAIL bp_op_count got %0d want 3", op_count); end
  endtask

  task automatic test_adc();
    int lat; logic [31:0] seq; logic [127:0] bus;
    issue(16'h0010, 16'h0020, ALU_ADC, 8'h01, lat, seq, bus);
    tests_run++; if (res_y !== 16'h0031) begin tests_failed++; $display("FAIL adc_y got %h want 0031", res_y); end
    tests_run++; if (seq !== 32'h0123_4567) begin tests_failed++; $display("FAIL adc_cmd_seq got %h want 01234567", seq); end
    tests_run++; if (lat !== 7) begin tests_failed++; $display("FAIL adc_latency got %0d want 7", lat); end
    tests_run++; if (bus[111:48] !== 64'h0010_0020_0001_0001)
      begin tests_failed++; $display("FAIL adc_bus_data got %h want 0010002000010001", bus[111:48]); end
    retire();
  endtask

  task automatic test_error();
    int lat; logic [31:0] seq; logic [127:0] bus;
    kill_f = 1'b1;
    issue(16'h0100, 16'h0200, ALU_ADD, 8'h00, lat, seq, bus);
    kill_f = 1'b0;
    tests_run++; if (res_err !== 1'b1) begin tests_failed++; $display("FAIL err_set got %0b want 1", res_err); end
    tests_run++; if (res_y !== 16'h0300) begin tests_failed++; $display("FAIL err_y got %h want 0300", res_y); end
    retire();
    issue(16'h0002, 16'h0002, ALU_ADD, 8'h00, lat, seq, bus);
    tests_run++; if (res_err !== 1'b0) begin tests_failed++; $display("FAIL err_clear got %0b want 0", res_err); end
    tests_run++; if (res_y !== 16'h0004) begin tests_failed++; $display("FAIL err_next_y got %h want 0004", res_y); end
    retire();
  endtask

  task automatic test_reset_midflight();
    int lat; logic [31:0] seq; logic [127:0] bus;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    req_a = 16'h1111; req_b = 16'h2222; req_op = ALU_ADD; req_flags = 8'h00; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    for (int w = 0; w < 10; w++) begin
      if (command == COM_COMPUTE) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL rst_reach_compute got %0b want 1", seen); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1 || command !== COM_NOP || res_valid !== 1'b0 || bus_valid !== 1'b0)
      begin tests_failed++; $display("FAIL rst_idle got rdy=%0b cmd=%0h vld=%0b bv=%0b want 1/0/0/0",
                                     req_ready, command, res_valid, bus_valid); end
    tests_run++; if (op_count !== 16'd0) begin tests_failed++; $display("FAIL rst_op_count got %0d want 0", op_count); end
    @(negedge clk); rst_n = 1'b1;
    issue(16'h0030, 16'h0004, ALU_ADD, 8'h00, lat, seq, bus);
    tests_run++; if (res_y !== 16'h0034 || lat !== ADD_LAT)
      begin tests_failed++; $display("FAIL rst_after_y got y=%h lat=%0d want 0034/%0d", res_y, lat, ADD_LAT); end
    retire();
    tests_run++; if (op_count !== 16'd1) begin tests_failed++; $display("FAIL rst_after_count got %0d want 1", op_count); end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_add();
    test_add_overflow();
    test_backpressure();
    test_adc();
    test_error();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
